sfa_pr_host: RTL and testbench
==============================

// Module: sfa_pr_host
// PURPOSE
//  Initiator side of the PR accelerator stream protocol: issues one command word on mCMD, feeds
//  paired operands on mIn1/mIn2, collects results from sOut and the return word from sRet.
//  Sits between host-side job control plus operand/result FIFOs and one PR slot.
//  Reports completion, the return code and a short/timeout error per job.
// PARAMETERS
//  DATA_W   32    width of command, operand, result and return words
//  CNT_W    16    width of job length and element counters
//  TIMEOUT  1024  idle cycles with no stream/ret handshake before abort; 0 = watchdog disabled
// PORTS
//  ACLK         in   1       clock
//  ARESET       in   1       asynchronous reset, active-high
//  start        in   1       job request; sampled only in IDLE
//  opcode       in   DATA_W  command word for the job
//  length       in   CNT_W   operand pairs to send and results to expect
//  busy         out  1       1 in every state except IDLE
//  done         out  1       1-cycle completion pulse
//  error        out  1       valid with done: short job or timeout
//  ret_code     out  DATA_W  return word of last job; held until next done
//  mCMD_t*      out/in       tvalid, tready(in), tdata[DATA_W] to PR command port
//  sA_t*, sB_t* in/out       upstream operand streams: tvalid, tdata[DATA_W] in; tready out
//  mIn1_t*, mIn2_t* out/in   operand streams to PR: tvalid, tdata[DATA_W] out; tready in
//  sOut_t*      in/out       PR result stream: tvalid, tdata in; tready out
//  mRes_t*      out/in       downstream result stream: tvalid, tdata out; tready in
//  sRet_t*      in/out       PR return word: tvalid, tdata in; tready out
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, counters=0, busy/done/error=0, ret_code=0, all tvalid/tready=0.
//  States: IDLE -> CMD -> STREAM -> WAIT_RET -> DONE -> IDLE.
//  IDLE: start=1 latches opcode,length; clears sent/rcvd/watchdog; -> CMD next cycle.
//  CMD: mCMD_tvalid=1, mCMD_tdata=opcode (registered). On tready -> STREAM, or WAIT_RET if length==0.
//  STREAM: fire = sA_tvalid & sB_tvalid & (sent<length); mIn1_tvalid=mIn2_tvalid=fire;
//   mIn1/2_tdata = sA/sB_tdata (pass-through); sA_tready=sB_tready=fire & mIn1_tready & mIn2_tready.
//   A pair moves only when all four handshakes occur in the same cycle; sent++ per pair.
//   tvalid never depends on any tready. sent==length -> WAIT_RET.
//  Results (STREAM and WAIT_RET): mRes_tvalid = sOut_tvalid & (rcvd<length), mRes_tdata = sOut_tdata,
//   sOut_tready = mRes_tready & (rcvd<length); rcvd++ per transfer. Results beyond length are stalled.
//  sRet_tready=1 in STREAM and WAIT_RET (responder may end early). On sRet handshake: ret_code<=sRet_tdata,
//   error<=(sent!=length)|(rcvd!=length) evaluated after the cycle's own increments; -> DONE.
//  Same-cycle last pair/result and sRet: all count and the ret is taken; no error.
//  Watchdog: in STREAM/WAIT_RET counts cycles with no pair, result or ret handshake; resets on any.
//   Reaching TIMEOUT -> DONE with error=1, ret_code=32'hFFFF_FFFF (all ones for DATA_W).
//  DONE: done=1 exactly one cycle, busy=1; -> IDLE. busy=0 the cycle after done.
//  start while busy is ignored (not queued). Latency start -> mCMD_tvalid = 1 cycle.
//  Counters CNT_W bits, never wrap (bounded by length). Reset mid-job abandons all transfers; no done.
// TESTING
//  1. length=4, opcode=1, A={1,2,3,4}, B={10,20,30,40}, PR returns 11..44 then ret=10
//     -> mIn1/mIn2 carry exact pairs, mRes=11,22,33,44, done pulse, ret_code=10, error=0.
//  2. Same job, mIn2_tready low on alternate cycles, mRes_tready low for 3 cycles
//     -> no pair split or duplicated, sA/sB consumed once each, results in order, error=0.
//  3. length=0 -> one mCMD beat, no mIn traffic, ret=10 accepted, done, error=0.
//  4. length=4, PR sends 3 results then ret=10 -> done, ret_code=10, error=1; 4th operand pair not sent.
//  5. TIMEOUT=16, PR never asserts sOut/sRet -> done 16 idle cycles after last handshake, error=1, ret_code=all ones.
//  6. ARESET asserted mid-STREAM at sent=2 -> all outputs 0 same cycle, IDLE; new start runs a clean job.

Source files
------------

// File: rtl/sfa_pr_host.sv
// Initiator for the PR accelerator stream protocol: one command beat, paired operand
// streaming, result forwarding, return-word capture and an idle watchdog per job.
module sfa_pr_host #(
   parameter int DATA_W  = 32,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              start,
   input  logic [DATA_W-1:0] opcode,
   input  logic [CNT_W-1:0]  length,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [DATA_W-1:0] ret_code,
   output logic              mCMD_tvalid,
   input  logic              mCMD_tready,
   output logic [DATA_W-1:0] mCMD_tdata,
   input  logic              sA_tvalid,
   input  logic [DATA_W-1:0] sA_tdata,
   output logic              sA_tready,
   input  logic              sB_tvalid,
   input  logic [DATA_W-1:0] sB_tdata,
   output logic              sB_tready,
   output logic              mIn1_tvalid,
   output logic [DATA_W-1:0] mIn1_tdata,
   input  logic              mIn1_tready,
   output logic              mIn2_tvalid,
   output logic [DATA_W-1:0] mIn2_tdata,
   input  logic              mIn2_tready,
   input  logic              sOut_tvalid,
   input  logic [DATA_W-1:0] sOut_tdata,
   output logic              sOut_tready,
   output logic              mRes_tvalid,
   output logic [DATA_W-1:0] mRes_tdata,
   input  logic              mRes_tready,
   input  logic              sRet_tvalid,
   input  logic [DATA_W-1:0] sRet_tdata,
   output logic              sRet_tready
);

   localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_STREAM,
      S_WAIT_RET,
      S_DONE
   } state_t;

   state_t            state, state_nx;
   logic [DATA_W-1:0] op_q;
   logic [DATA_W-1:0] ret_q;
   logic [CNT_W-1:0]  len_q;
   logic [CNT_W-1:0]  sent, rcvd;
   logic [CNT_W-1:0]  sent_nx, rcvd_nx;
   logic [WD_W-1:0]   wdog, wdog_nx;
   logic              err_q;

   logic active;
   logic send_ok, res_ok;
   logic fire;
   logic pair_xfer, res_xfer, ret_xfer, any_xfer;
   logic timeout_hit;

   // Handshake qualification; tvalid terms never look at any tready.
   always_comb begin
      active      = (state == S_STREAM) || (state == S_WAIT_RET);
      send_ok     = sent < len_q;
      res_ok      = rcvd < len_q;
      fire        = (state == S_STREAM) && sA_tvalid && sB_tvalid && send_ok;
      pair_xfer   = fire && mIn1_tready && mIn2_tready;
      res_xfer    = active && res_ok && sOut_tvalid && mRes_tready;
      ret_xfer    = active && sRet_tvalid;
      any_xfer    = pair_xfer || res_xfer || ret_xfer;
      sent_nx     = sent + CNT_W'(pair_xfer);
      rcvd_nx     = rcvd + CNT_W'(res_xfer);
      wdog_nx     = any_xfer ? '0 : wdog + WD_W'(1);
      timeout_hit = (TIMEOUT != 0) && active && !any_xfer && (wdog_nx == WD_W'(TIMEOUT));
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:     if (start) state_nx = S_CMD;
         S_CMD:      if (mCMD_tready) state_nx = (len_q == '0) ? S_WAIT_RET : S_STREAM;
         S_STREAM: begin
            if (ret_xfer || timeout_hit) state_nx = S_DONE;
            else if (sent_nx == len_q)   state_nx = S_WAIT_RET;
         end
         S_WAIT_RET: if (ret_xfer || timeout_hit) state_nx = S_DONE;
         S_DONE:     state_nx = S_IDLE;
         default:    state_nx = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state <= S_IDLE;
         op_q  <= '0;
         ret_q <= '0;
         len_q <= '0;
         sent  <= '0;
         rcvd  <= '0;
         wdog  <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && start) begin
            op_q  <= opcode;
            len_q <= length;
            sent  <= '0;
            rcvd  <= '0;
            wdog  <= '0;
         end
         if (active) begin
            sent <= sent_nx;
            rcvd <= rcvd_nx;
            wdog <= (TIMEOUT == 0) ? '0 : wdog_nx;
            // Error uses post-increment counts so a same-cycle final beat is not short.
            if (ret_xfer) begin
               ret_q <= sRet_tdata;
               err_q <= (sent_nx != len_q) || (rcvd_nx != len_q);
            end else if (timeout_hit) begin
               ret_q <= '1;
               err_q <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      busy        = (state != S_IDLE);
      done        = (state == S_DONE);
      error       = (state == S_DONE) && err_q;
      ret_code    = ret_q;
      mCMD_tvalid = (state == S_CMD);
      mCMD_tdata  = op_q;
      mIn1_tvalid = fire;
      mIn2_tvalid = fire;
      mIn1_tdata  = sA_tdata;
      mIn2_tdata  = sB_tdata;
      sA_tready   = pair_xfer;
      sB_tready   = pair_xfer;
      mRes_tvalid = active && res_ok && sOut_tvalid;
      mRes_tdata  = sOut_tdata;
      sOut_tready = active && res_ok && mRes_tready;
      sRet_tready = active;
   end

endmodule

// File: tb/tb_sfa_pr_host.sv
// Directed bench for sfa_pr_host: behavioural upstream source, PR slot and result sink
// driven cycle by cycle, with hand-computed expectations per job.
module tb_sfa_pr_host;

   localparam int DW = 32;
   localparam int CW = 16;

   logic          ACLK = 1'b0;
   logic          ARESET = 1'b1;
   logic          start = 1'b0;
   logic [DW-1:0] opcode = '0;
   logic [CW-1:0] length = '0;
   logic          busy, done, error;
   logic [DW-1:0] ret_code;
   logic          mCMD_tvalid, mCMD_tready = 1'b0;
   logic [DW-1:0] mCMD_tdata;
   logic          sA_tvalid = 1'b0, sA_tready;
   logic [DW-1:0] sA_tdata = '0;
   logic          sB_tvalid = 1'b0, sB_tready;
   logic [DW-1:0] sB_tdata = '0;
   logic          mIn1_tvalid, mIn1_tready = 1'b0;
   logic [DW-1:0] mIn1_tdata;
   logic          mIn2_tvalid, mIn2_tready = 1'b0;
   logic [DW-1:0] mIn2_tdata;
   logic          sOut_tvalid = 1'b0, sOut_tready;
   logic [DW-1:0] sOut_tdata = '0;
   logic          mRes_tvalid, mRes_tready = 1'b0;
   logic [DW-1:0] mRes_tdata;
   logic          sRet_tvalid = 1'b0, sRet_tready;
   logic [DW-1:0] sRet_tdata = '0;

   always #5 ACLK = ~ACLK;

   sfa_pr_host #(.DATA_W(DW), .CNT_W(CW), .TIMEOUT(16)) dut (
      .ACLK(ACLK), .ARESET(ARESET), .start(start), .opcode(opcode), .length(length),
      .busy(busy), .done(done), .error(error), .ret_code(ret_code),
      .mCMD_tvalid(mCMD_tvalid), .mCMD_tready(mCMD_tready), .mCMD_tdata(mCMD_tdata),
      .sA_tvalid(sA_tvalid), .sA_tdata(sA_tdata), .sA_tready(sA_tready),
      .sB_tvalid(sB_tvalid), .sB_tdata(sB_tdata), .sB_tready(sB_tready),
      .mIn1_tvalid(mIn1_tvalid), .mIn1_tdata(mIn1_tdata), .mIn1_tready(mIn1_tready),
      .mIn2_tvalid(mIn2_tvalid), .mIn2_tdata(mIn2_tdata), .mIn2_tready(mIn2_tready),
      .sOut_tvalid(sOut_tvalid), .sOut_tdata(sOut_tdata), .sOut_tready(sOut_tready),
      .mRes_tvalid(mRes_tvalid), .mRes_tdata(mRes_tdata), .mRes_tready(mRes_tready),
      .sRet_tvalid(sRet_tvalid), .sRet_tdata(sRet_tdata), .sRet_tready(sRet_tready)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Environment model state
   logic [DW-1:0] a_vals[8], b_vals[8], r_vals[8];
   logic [DW-1:0] in1_log[8], in2_log[8], res_log[8];
   logic [DW-1:0] cmd_data, done_ret, ret_val;
   int  a_idx, b_idx, pairs_in, out_idx, res_cnt, cmd_cnt, split_cnt;
   int  idle, idle_at_done, done_cnt, cyc;
   int  n_a, pr_max, res_n, ret_after, stall_from, stall_len;
   bit  ret_taken, got_done, done_err, in2_alt, ret_en, ret_with_last;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      a_idx = 0; b_idx = 0; pairs_in = 0; out_idx = 0; res_cnt = 0; cmd_cnt = 0;
      split_cnt = 0; idle = 0; idle_at_done = -1;
      ret_taken = 0; got_done = 0; done_err = 0; done_ret = '0; cmd_data = '0;
      in2_alt = 0; ret_en = 1; ret_with_last = 0; stall_from = 0; stall_len = 0;
      ret_val = 32'd10;
      for (int i = 0; i < 8; i++) begin
         in1_log[i] = '0; in2_log[i] = '0; res_log[i] = '0;
         a_vals[i] = 32'(i + 1); b_vals[i] = 32'(10 * (i + 1)); r_vals[i] = 32'(11 * (i + 1));
      end
   endtask

   task automatic drive();
      sA_tvalid   = (a_idx < n_a);
      sA_tdata    = (a_idx < 8) ? a_vals[a_idx] : '0;
      sB_tvalid   = (b_idx < n_a);
      sB_tdata    = (b_idx < 8) ? b_vals[b_idx] : '0;
      mIn1_tready = (pairs_in < pr_max);
      mIn2_tready = (pairs_in < pr_max) && !(in2_alt && cyc[0]);
      sOut_tvalid = (out_idx < res_n) && (out_idx < pairs_in);
      sOut_tdata  = (out_idx < 8) ? r_vals[out_idx] : '0;
      if (ret_with_last)
         sRet_tvalid = ret_en && !ret_taken && (pairs_in >= ret_after) &&
                       (out_idx + 1 == res_n) && sOut_tvalid;
      else
         sRet_tvalid = ret_en && !ret_taken && (pairs_in >= ret_after) && (out_idx == res_n);
      sRet_tdata  = ret_val;
      mRes_tready = !((cyc >= stall_from) && (cyc < stall_from + stall_len));
      mCMD_tready = 1'b1;
   endtask

   task automatic sample();
      bit pair, hs;
      pair = mIn1_tvalid && mIn1_tready && mIn2_tvalid && mIn2_tready;
      if (pair != (sA_tvalid && sA_tready)) split_cnt++;
      if (mIn1_tvalid != mIn2_tvalid) split_cnt++;
      if (sA_tready != sB_tready) split_cnt++;
      if (sA_tvalid && sA_tready) a_idx++;
      if (sB_tvalid && sB_tready) b_idx++;
      if (pair) begin
         if (pairs_in < 8) begin
            in1_log[pairs_in] = mIn1_tdata;
            in2_log[pairs_in] = mIn2_tdata;
         end
         pairs_in++;
      end
      if (sOut_tvalid && sOut_tready) out_idx++;
      if (mRes_tvalid && mRes_tready) begin
         if (res_cnt < 8) res_log[res_cnt] = mRes_tdata;
         res_cnt++;
      end
      if (sRet_tvalid && sRet_tready) ret_taken = 1;
      if (mCMD_tvalid && mCMD_tready) begin
         cmd_cnt++;
         cmd_data = mCMD_tdata;
      end
      hs = pair || (sOut_tvalid && sOut_tready) || (sRet_tvalid && sRet_tready);
      if (done) begin
         got_done = 1; done_cnt++; done_ret = ret_code; done_err = error; idle_at_done = idle;
      end else if (busy && !mCMD_tvalid) begin
         idle = hs ? 0 : idle + 1;
      end
      cyc++;
   endtask

   // One clock: drive at the falling edge, sample just before the rising edge.
   task automatic cycle();
      drive();
      #3;
      sample();
      @(negedge ACLK);
   endtask

   task automatic run_job(input logic [DW-1:0] op, input logic [CW-1:0] len, input int glitch_at);
      int n;
      start = 1'b1; opcode = op; length = len;
      cycle();
      start = 1'b0;
      check("cmd_latency", 32'(mCMD_tvalid), 1);
      check("cmd_tdata", mCMD_tdata, op);
      n = 0;
      while (!got_done && n < 100) begin
         start = (n == glitch_at);
         cycle();
         n++;
      end
      start = 1'b0;
      check("done_seen", 32'(got_done), 1);
      check("done_one_cycle", 32'(done), 0);
      check("busy_after_done", 32'(busy), 0);
      check("cmd_beats", cmd_cnt, 1);
      check("cmd_word", cmd_data, op);
      check("no_split", split_cnt, 0);
   endtask

   task automatic check_full_job(input string tag);
      check({tag, "_pairs"}, pairs_in, 4);
      check({tag, "_a_used"}, a_idx, 4);
      check({tag, "_b_used"}, b_idx, 4);
      check({tag, "_results"}, res_cnt, 4);
      for (int i = 0; i < 4; i++) begin
         check({tag, "_in1"}, in1_log[i], 32'(i + 1));
         check({tag, "_in2"}, in2_log[i], 32'(10 * (i + 1)));
         check({tag, "_res"}, res_log[i], 32'(11 * (i + 1)));
      end
      check({tag, "_ret"}, done_ret, 32'd10);
      check({tag, "_err"}, 32'(done_err), 0);
   endtask

   initial begin
      int n;
      int dc;
      reset_model();
      done_cnt = 0; cyc = 0;
      n_a = 0; pr_max = 0; res_n = 0; ret_after = 0;
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_error", 32'(error), 0);
      check("rst_ret", ret_code, 0);
      check("rst_cmd_valid", 32'(mCMD_tvalid), 0);
      @(negedge ACLK);
      ARESET = 1'b0;

      // 1: basic four-pair job
      reset_model(); n_a = 4; pr_max = 4; res_n = 4; ret_after = 4;
      run_job(32'd1, 16'd4, -1);
      check_full_job("t1");

      // 2: mIn2 back-pressure on alternate cycles, 3-cycle result stall, start while busy
      reset_model(); n_a = 4; pr_max = 4; res_n = 4; ret_after = 4;
      in2_alt = 1; stall_from = cyc + 3; stall_len = 3;
      run_job(32'd1, 16'd4, 3);
      check_full_job("t2");
      cycle();
      check("t2_start_ignored", 32'(busy), 0);

      // 3: zero-length job
      reset_model(); n_a = 4; pr_max = 4; res_n = 0; ret_after = 0;
      run_job(32'd7, 16'd0, -1);
      check("t3_pairs", pairs_in, 0);
      check("t3_results", res_cnt, 0);
      check("t3_ret", done_ret, 32'd10);
      check("t3_err", 32'(done_err), 0);

      // 4: responder ends early after three pairs/results
      reset_model(); n_a = 4; pr_max = 3; res_n = 3; ret_after = 3;
      run_job(32'd1, 16'd4, -1);
      check("t4_pairs", pairs_in, 3);
      check("t4_a_used", a_idx, 3);
      check("t4_results", res_cnt, 3);
      check("t4_ret", done_ret, 32'd10);
      check("t4_err", 32'(done_err), 1);

      // 5: watchdog, responder silent after operands
      reset_model(); n_a = 2; pr_max = 2; res_n = 0; ret_en = 0;
      run_job(32'd3, 16'd2, -1);
      check("t5_pairs", pairs_in, 2);
      check("t5_idle_cycles", idle_at_done, 16);
      check("t5_ret", done_ret, 32'hFFFF_FFFF);
      check("t5_err", 32'(done_err), 1);
      check("t5_ret_held", ret_code, 32'hFFFF_FFFF);

      // 7: last result and ret in the same cycle
      reset_model(); n_a = 2; pr_max = 2; res_n = 2; ret_after = 2;
      ret_with_last = 1; ret_val = 32'd55;
      run_job(32'd9, 16'd2, -1);
      check("t7_results", res_cnt, 2);
      check("t7_ret", done_ret, 32'd55);
      check("t7_err", 32'(done_err), 0);

      // 6: reset mid-stream at sent=2, then a clean job
      reset_model(); n_a = 4; pr_max = 4; res_n = 0; ret_en = 0;
      start = 1'b1; opcode = 32'd1; length = 16'd4;
      cycle();
      start = 1'b0;
      n = 0;
      while (pairs_in < 2 && n < 50) begin
         cycle();
         n++;
      end
      check("t6_two_pairs", pairs_in, 2);
      dc = done_cnt;
      drive();
      ARESET = 1'b1;
      #1;
      check("t6_busy", 32'(busy), 0);
      check("t6_in1_valid", 32'(mIn1_tvalid), 0);
      check("t6_a_ready", 32'(sA_tready), 0);
      check("t6_ret_ready", 32'(sRet_tready), 0);
      check("t6_ret_code", ret_code, 0);
      check("t6_error", 32'(error), 0);
      @(negedge ACLK);
      ARESET = 1'b0;
      cycle();
      check("t6_no_done", done_cnt, dc);
      reset_model(); n_a = 4; pr_max = 4; res_n = 4; ret_after = 4;
      run_job(32'd1, 16'd4, -1);
      check_full_job("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "bench time limit reached");
   end

endmodule
